bsg_counter_overflow_multi: RTL and testbench

BSG_COUNTER_OVERFLOW_MULTI -- requirements
Module: bsg_counter_overflow_multi

---
 rtl/bsg_counter_pkg.sv | 14 +
 rtl/bsg_counter_overflow_chan.sv | 71 +++++++
 rtl/bsg_counter_overflow_multi.sv | 58 +++++
 tb/tb_bsg_counter_overflow_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_counter_pkg.sv
// Shared types and helpers for the multi-channel overflow counter.
package bsg_counter_pkg;

    typedef enum logic {
        e_wrap     = 1'b0,
        e_saturate = 1'b1
    } bsg_counter_mode_e;

    // Address width for a channel count, never narrower than one bit.
    function automatic int unsigned lg_els(input int unsigned els);
        return (els <= 1) ? 1 : $clog2(els);
    endfunction

endpackage

// File: rtl/bsg_counter_overflow_chan.sv
// One counter channel: count, limit, overflow pulse and sticky overflow flag.
module bsg_counter_overflow_chan
    import bsg_counter_pkg::*;
#(
    parameter int unsigned          width_p     = 32,
    parameter logic [width_p-1:0]   max_reset_p = '0,
    parameter bsg_counter_mode_e    mode_p      = e_wrap
)
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic                set_i,
    input  logic [width_p-1:0]  val_i,
    input  logic                limit_we_i,
    input  logic [width_p-1:0]  limit_data_i,
    input  logic                clear_i,
    output logic [width_p-1:0]  count_o,
    output logic                at_limit_o,
    output logic                wrap_o,
    output logic                sticky_o
);

    logic [width_p-1:0] count_q, count_d;
    logic [width_p-1:0] limit_q, limit_d;
    logic               wrap_q, wrap_d;
    logic               sticky_q, sticky_d;
    logic               at_limit;
    logic               overflow;

    // Load beats increment; an increment at or past the limit wraps or pins.
    always_comb begin
        at_limit = (count_q >= limit_q);
        overflow = en_i & ~set_i & at_limit;
        count_d  = count_q;
        if (set_i) begin
            count_d = val_i;
        end else if (en_i) begin
            if (!at_limit) begin
                count_d = count_q + width_p'(1);
            end else if (mode_p == e_saturate) begin
                count_d = limit_q;
            end else begin
                count_d = '0;
            end
        end
        limit_d  = limit_we_i ? limit_data_i : limit_q;
        wrap_d   = overflow;
        sticky_d = overflow | (sticky_q & ~clear_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q  <= '0;
            limit_q  <= max_reset_p;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            limit_q  <= limit_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_d;
        end
    end

    assign count_o    = count_q;
    assign at_limit_o = at_limit;
    assign wrap_o     = wrap_q;
    assign sticky_o   = sticky_q;

endmodule

// File: rtl/bsg_counter_overflow_multi.sv
// Bank of independent overflow counters sharing one limit write port.
module bsg_counter_overflow_multi
    import bsg_counter_pkg::*;
#(
    parameter int unsigned          width_p     = 32,
    parameter int unsigned          els_p       = 4,
    parameter int unsigned          max_reset_p = 1000,
    parameter bsg_counter_mode_e    mode_p      = e_wrap,
    localparam int unsigned         lg_els_lp   = lg_els(els_p)
)
(
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [els_p-1:0]            en_i,
    input  logic [els_p-1:0]            set_i,
    input  logic [els_p*width_p-1:0]    val_i,
    input  logic                        limit_w_v_i,
    input  logic [lg_els_lp-1:0]        limit_w_addr_i,
    input  logic [width_p-1:0]          limit_w_data_i,
    input  logic [els_p-1:0]            clear_i,
    output logic [els_p*width_p-1:0]    count_o,
    output logic [els_p-1:0]            at_limit_o,
    output logic [els_p-1:0]            wrap_o,
    output logic [els_p-1:0]            sticky_o
);

    logic [els_p-1:0] limit_we;

    // Only in-range addresses can match, so out-of-range writes fall away.
    always_comb begin
        limit_we = '0;
        for (int unsigned i = 0; i < els_p; i++) begin
            limit_we[i] = limit_w_v_i && (limit_w_addr_i == lg_els_lp'(i));
        end
    end

    for (genvar i = 0; i < els_p; i++) begin : g_chan
        bsg_counter_overflow_chan #(
            .width_p     (width_p),
            .max_reset_p (width_p'(max_reset_p)),
            .mode_p      (mode_p)
        ) u_chan (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .en_i         (en_i[i]),
            .set_i        (set_i[i]),
            .val_i        (val_i[i*width_p +: width_p]),
            .limit_we_i   (limit_we[i]),
            .limit_data_i (limit_w_data_i),
            .clear_i      (clear_i[i]),
            .count_o      (count_o[i*width_p +: width_p]),
            .at_limit_o   (at_limit_o[i]),
            .wrap_o       (wrap_o[i]),
            .sticky_o     (sticky_o[i])
        );
    end

endmodule

// File: tb/tb_bsg_counter_overflow_multi.sv
// Directed bench: wrap/saturate/5-channel instances checked against a behavioural model.
module tb_bsg_counter_overflow_multi;
    import bsg_counter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  en, set, clr;
    logic [39:0] val_flat;
    logic        lw_v;
    logic [2:0]  lw_addr;
    logic [7:0]  lw_data;

    logic [31:0] cnt_a, cnt_b;
    logic [39:0] cnt_c;
    logic [3:0]  atl_a, atl_b, wrap_a, wrap_b, stk_a, stk_b;
    logic [4:0]  atl_c, wrap_c, stk_c;

    int checks = 0;
    int failures = 0;
    bit compare_on = 1'b0;

    // Model state: index 0 = wrap/4ch, 1 = saturate/4ch, 2 = wrap/5ch.
    logic [7:0] m_cnt [3][5];
    logic [7:0] m_lim [3][5];
    logic       m_wrap [3][5];
    logic       m_stk [3][5];

    always #5 clk = ~clk;

    // 4-channel instances see only in-range addresses; the 5-channel one sees all.
    bsg_counter_overflow_multi #(.width_p(8), .els_p(4), .max_reset_p(9), .mode_p(e_wrap)) dut_a (
        .clk_i(clk), .reset_i(rst), .en_i(en[3:0]), .set_i(set[3:0]), .val_i(val_flat[31:0]),
        .limit_w_v_i(lw_v && (lw_addr < 3'd4)), .limit_w_addr_i(lw_addr[1:0]),
        .limit_w_data_i(lw_data), .clear_i(clr[3:0]), .count_o(cnt_a), .at_limit_o(atl_a),
        .wrap_o(wrap_a), .sticky_o(stk_a));

    bsg_counter_overflow_multi #(.width_p(8), .els_p(4), .max_reset_p(9), .mode_p(e_saturate)) dut_b (
        .clk_i(clk), .reset_i(rst), .en_i(en[3:0]), .set_i(set[3:0]), .val_i(val_flat[31:0]),
        .limit_w_v_i(lw_v && (lw_addr < 3'd4)), .limit_w_addr_i(lw_addr[1:0]),
        .limit_w_data_i(lw_data), .clear_i(clr[3:0]), .count_o(cnt_b), .at_limit_o(atl_b),
        .wrap_o(wrap_b), .sticky_o(stk_b));

    bsg_counter_overflow_multi #(.width_p(8), .els_p(5), .max_reset_p(9), .mode_p(e_wrap)) dut_c (
        .clk_i(clk), .reset_i(rst), .en_i(en), .set_i(set), .val_i(val_flat),
        .limit_w_v_i(lw_v), .limit_w_addr_i(lw_addr), .limit_w_data_i(lw_data),
        .clear_i(clr), .count_o(cnt_c), .at_limit_o(atl_c), .wrap_o(wrap_c), .sticky_o(stk_c));

    function automatic int n_els(input int d);
        return (d == 2) ? 5 : 4;
    endfunction

    // Behavioural model: the count rules stated as plain arithmetic per channel.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 5; i++) begin
                    m_cnt[d][i]  <= 8'd0;
                    m_lim[d][i]  <= 8'd9;
                    m_wrap[d][i] <= 1'b0;
                    m_stk[d][i]  <= 1'b0;
                end
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < n_els(d); i++) begin
                    automatic logic [7:0] c   = m_cnt[d][i];
                    automatic logic [7:0] l   = m_lim[d][i];
                    automatic bit         hit = (c >= l);
                    automatic bit         ev  = en[i] && !set[i] && hit;
                    if (set[i])
                        m_cnt[d][i] <= val_flat[i*8 +: 8];
                    else if (en[i])
                        m_cnt[d][i] <= hit ? ((d == 1) ? l : 8'd0) : 8'(int'(c) + 1);
                    m_wrap[d][i] <= ev;
                    m_stk[d][i]  <= ev || (m_stk[d][i] && !clr[i]);
                    if (lw_v && (int'(lw_addr) == i) && (int'(lw_addr) < n_els(d)))
                        m_lim[d][i] <= lw_data;
                end
            end
        end
    end

    function automatic logic [7:0] dut_cnt(input int d, input int i);
        logic [39:0] v;
        case (d)
            0:       v = {8'h00, cnt_a};
            1:       v = {8'h00, cnt_b};
            default: v = cnt_c;
        endcase
        return v[i*8 +: 8];
    endfunction

    // k: 0 = wrap, 1 = sticky, 2 = at_limit
    function automatic logic [4:0] dut_bits(input int d, input int k);
        logic [4:0] v;
        case (d)
            0:       v = (k == 0) ? {1'b0, wrap_a} : (k == 1) ? {1'b0, stk_a} : {1'b0, atl_a};
            1:       v = (k == 0) ? {1'b0, wrap_b} : (k == 1) ? {1'b0, stk_b} : {1'b0, atl_b};
            default: v = (k == 0) ? wrap_c : (k == 1) ? stk_c : atl_c;
        endcase
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] exp);
        check(nm, act, exp);
        check({nm, "/model"}, mdl, exp);
    endtask

    always @(negedge clk) begin
        if (compare_on) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < n_els(d); i++) begin
                    automatic logic [4:0] w = dut_bits(d, 0);
                    automatic logic [4:0] s = dut_bits(d, 1);
                    automatic logic [4:0] a = dut_bits(d, 2);
                    check($sformatf("count d%0d c%0d", d, i), 32'(dut_cnt(d, i)), 32'(m_cnt[d][i]));
                    check($sformatf("wrap d%0d c%0d", d, i), 32'(w[i]), 32'(m_wrap[d][i]));
                    check($sformatf("sticky d%0d c%0d", d, i), 32'(s[i]), 32'(m_stk[d][i]));
                    check($sformatf("at_limit d%0d c%0d", d, i), 32'(a[i]),
                          32'(m_cnt[d][i] >= m_lim[d][i]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        en = '0; set = '0; clr = '0; lw_v = 1'b0;
    endtask

    task automatic setv(input int ch, input logic [7:0] v);
        val_flat[ch*8 +: 8] = v;
    endtask

    initial begin
        en = '0; set = '0; clr = '0; val_flat = '0;
        lw_v = 1'b0; lw_addr = '0; lw_data = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        compare_on = 1'b1;
        repeat (2) step();
        lit("reset count a0", 32'(cnt_a[7:0]), 32'(m_cnt[0][0]), 0);
        lit("reset sticky a", 32'(stk_a), 32'(m_stk[0][0]), 0);
        lit("reset at_limit c", 32'(atl_c), 32'(m_cnt[2][4] >= m_lim[2][4]), 0);
        rst = 1'b0;

        // Wrap channel 0: 0..9 then back to 0 with one pulse.
        en[0] = 1'b1;
        repeat (9) step();
        lit("ch0 count at 9", 32'(cnt_a[7:0]), 32'(m_cnt[0][0]), 9);
        lit("ch0 at_limit", 32'(atl_a[0]), 32'(m_cnt[0][0] >= m_lim[0][0]), 1);
        step();
        lit("ch0 wrapped", 32'(cnt_a[7:0]), 32'(m_cnt[0][0]), 0);
        lit("ch0 wrap pulse", 32'(wrap_a[0]), 32'(m_wrap[0][0]), 1);
        lit("ch0 sticky", 32'(stk_a[0]), 32'(m_stk[0][0]), 1);
        en[0] = 1'b0;
        step();
        lit("ch0 pulse ends", 32'(wrap_a[0]), 32'(m_wrap[0][0]), 0);
        lit("ch0 sticky held", 32'(stk_a[0]), 32'(m_stk[0][0]), 1);

        // Load beats an overflowing increment.
        set[1] = 1'b1; setv(1, 8'd9);
        step();
        lit("ch1 loaded 9", 32'(cnt_a[15:8]), 32'(m_cnt[0][1]), 9);
        setv(1, 8'd3); en[1] = 1'b1;
        step();
        lit("ch1 set wins", 32'(cnt_a[15:8]), 32'(m_cnt[0][1]), 3);
        lit("ch1 no wrap", 32'(wrap_a[1]), 32'(m_wrap[0][1]), 0);
        lit("ch1 sticky unchanged", 32'(stk_a[1]), 32'(m_stk[0][1]), 0);
        idle();

        // Lower the limit under the count, then increment.
        set[2] = 1'b1; setv(2, 8'd7);
        step();
        set[2] = 1'b0;
        lw_v = 1'b1; lw_addr = 3'd2; lw_data = 8'd5;
        step();
        lw_v = 1'b0;
        lit("ch2 above new limit", 32'(atl_a[2]), 32'(m_cnt[0][2] >= m_lim[0][2]), 1);
        en[2] = 1'b1;
        step();
        lit("ch2 wrapped", 32'(cnt_a[23:16]), 32'(m_cnt[0][2]), 0);
        lit("ch2 wrap pulse", 32'(wrap_a[2]), 32'(m_wrap[0][2]), 1);
        lit("ch2 sat to limit", 32'(cnt_b[23:16]), 32'(m_cnt[1][2]), 5);
        // Same-cycle limit write: this increment still sees the old limit of 5.
        lw_v = 1'b1; lw_addr = 3'd2; lw_data = 8'd0;
        step();
        lw_v = 1'b0;
        lit("ch2 old limit used", 32'(cnt_a[23:16]), 32'(m_cnt[0][2]), 1);
        lit("ch2 no wrap yet", 32'(wrap_a[2]), 32'(m_wrap[0][2]), 0);
        step();
        lit("ch2 new limit used", 32'(cnt_a[23:16]), 32'(m_cnt[0][2]), 0);
        lit("ch2 wrap again", 32'(wrap_a[2]), 32'(m_wrap[0][2]), 1);
        idle();

        // Saturating channel 3 pinned at its limit.
        set[3] = 1'b1; setv(3, 8'd9);
        step();
        set[3] = 1'b0; en[3] = 1'b1;
        step();
        lit("sat ch3 hold 1", 32'(cnt_b[31:24]), 32'(m_cnt[1][3]), 9);
        lit("sat ch3 wrap 1", 32'(wrap_b[3]), 32'(m_wrap[1][3]), 1);
        step();
        lit("sat ch3 wrap 2", 32'(wrap_b[3]), 32'(m_wrap[1][3]), 1);
        clr[3] = 1'b1;
        step();
        lit("sat ch3 hold 3", 32'(cnt_b[31:24]), 32'(m_cnt[1][3]), 9);
        lit("sat ch3 wrap 3", 32'(wrap_b[3]), 32'(m_wrap[1][3]), 1);
        lit("sat set beats clear", 32'(stk_b[3]), 32'(m_stk[1][3]), 1);
        en[3] = 1'b0;
        step();
        lit("sat clear alone", 32'(stk_b[3]), 32'(m_stk[1][3]), 0);
        lit("sat wrap idle", 32'(wrap_b[3]), 32'(m_wrap[1][3]), 0);
        idle();

        // Reset mid-count with a pending load and limit write.
        set[0] = 1'b1; setv(0, 8'd0);
        step();
        set[0] = 1'b0; en[0] = 1'b1;
        repeat (6) step();
        lit("ch0 count 6", 32'(cnt_a[7:0]), 32'(m_cnt[0][0]), 6);
        set[1] = 1'b1; setv(1, 8'h55);
        lw_v = 1'b1; lw_addr = 3'd0; lw_data = 8'd2;
        rst = 1'b1;
        #1;
        lit("async reset count a", cnt_a, 32'(m_cnt[0][0]), 0);
        lit("async reset count b", cnt_b, 32'(m_cnt[1][3]), 0);
        lit("async reset sticky a", 32'(stk_a), 32'(m_stk[0][0]), 0);
        step();
        set = '0;
        lw_v = 1'b1; lw_addr = 3'd5; lw_data = 8'd0;
        rst = 1'b0;
        step();
        lit("post reset from 0", 32'(cnt_a[7:0]), 32'(m_cnt[0][0]), 1);
        lit("post reset ch1 clean", 32'(cnt_a[15:8]), 32'(m_cnt[0][1]), 0);
        lw_addr = 3'd6;
        step();
        lw_addr = 3'd7;
        step();
        lw_v = 1'b0;
        lit("out of range ignored", 32'(atl_c), 32'(m_cnt[2][1] >= m_lim[2][1]), 0);
        lw_v = 1'b1; lw_addr = 3'd4; lw_data = 8'd0;
        step();
        lw_v = 1'b0;
        lit("addr 4 written", 32'(atl_c), 32'({m_cnt[2][4] >= m_lim[2][4], 4'b0000}), 32'h10);
        repeat (5) step();
        lit("limit reset to 9", 32'(cnt_a[7:0]), 32'(m_cnt[0][0]), 9);
        lit("limit reset at_limit", 32'(atl_a[0]), 32'(m_cnt[0][0] >= m_lim[0][0]), 1);
        idle();

        // All-ones limit: wrap goes to 0, saturate holds 255.
        lw_v = 1'b1; lw_addr = 3'd2; lw_data = 8'hff;
        set[2] = 1'b1; setv(2, 8'hff);
        step();
        idle();
        en[2] = 1'b1;
        step();
        lit("ones wrap to 0", 32'(cnt_a[23:16]), 32'(m_cnt[0][2]), 0);
        lit("ones wrap pulse", 32'(wrap_a[2]), 32'(m_wrap[0][2]), 1);
        lit("ones saturate hold", 32'(cnt_b[23:16]), 32'(m_cnt[1][2]), 8'hff);
        idle();
        repeat (2) step();

        compare_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
